data_mem_if: RTL
================

Name: data_mem_if

Overview:
- Load/store unit sitting directly downstream of the core controller; consumes its RREQ/CWE pulses plus ALU-computed address and rs2 data.
- Runs one word-wide handshake transaction on the data-memory bus, then returns RDY.
- Performs byte-lane steering and byte enables for stores.
- Performs lane extraction and sign/zero extension of load data for the register file write-back mux (CMUXSEL=0 path).

Parameters:
- AW, 32, byte-address width.
- DW, 32, data width; fixed at 32 (four byte lanes).
- TIMEOUT, 16, cycles to wait for MEM_ACK before aborting; used only with DMEM_TIMEOUT_EN.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST_N  in  1  asynchronous active-low reset.
- RREQ  in  1  load request pulse from controller.
- CWE  in  1  store request pulse from controller.
- FUNCT3  in  3  instruction funct3; selects width and signedness.
- ADDR  in  AW  byte address (ALU result).
- WDATA  in  DW  store data (rs2), right-aligned.
- RDY  out  1  unit idle / last transaction complete (level).
- RDATA  out  DW  extended load result; held until the next load completes.
- ERR  out  1  last transaction faulted (misaligned, illegal funct3, or timeout).
- MEM_ADDR  out  AW  word-aligned address ({ADDR[AW-1:2],2'b00}).
- MEM_WDATA  out  DW  lane-steered store data.
- MEM_BE  out  4  byte enables.
- MEM_RE  out  1  read strobe.
- MEM_WE  out  1  write strobe.
- MEM_RDATA  in  DW  read data; valid when MEM_ACK=1.
- MEM_ACK  in  1  memory completion, one cycle.

Behaviour:
- Reset (RST_N=0, async):
  - State=IDLE; RDY=1; ERR=0; RDATA=0.
  - MEM_RE=MEM_WE=0; MEM_BE=0; MEM_ADDR=0; MEM_WDATA=0.
  - Reset mid-transaction abandons it; the memory strobes drop immediately.
- States: IDLE, ACCESS, RESP.
- IDLE:
  - On a rising edge with RREQ|CWE=1, latch FUNCT3, ADDR and WDATA; RDY goes to 0 next cycle.
  - If both RREQ and CWE are high: the store wins and ERR is set at completion.
  - Validity check at acceptance:
    - Loads: funct3 in {000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU}.
    - Stores: funct3 in {000 SB, 001 SH, 010 SW}.
    - Alignment: halfword requires ADDR[0]=0; word requires ADDR[1:0]=0.
  - Invalid request: go to RESP directly, ERR=1, no memory strobe, RDATA unchanged.
  - Valid request: go to ACCESS.
- ACCESS:
  - MEM_RE or MEM_WE held at 1 with stable MEM_ADDR, MEM_BE and MEM_WDATA until the MEM_ACK cycle.
  - Strobes drop in the cycle after MEM_ACK; then go to RESP.
  - Loads capture MEM_RDATA on the MEM_ACK edge.
  - An ACK in the same cycle the strobe first rises is legal (minimum latency).
- RESP:
  - One cycle; RDATA and ERR are updated.
  - RDY=1 from the next cycle, then state returns to IDLE.
  - Best-case request to RDY: 3 cycles.
- Store lanes:
  - SB: BE=4'b0001<<ADDR[1:0]; byte replicated on all lanes.
  - SH: BE=4'b0011<<ADDR[1:0]; half replicated.
  - SW: BE=4'b1111.
- Load extraction: select the byte/half at ADDR[1:0]; sign-extend for LB/LH, zero-extend for LBU/LHU.
- Requests arriving while RDY=0 are ignored (not queued).
- RDY stays 1 in IDLE indefinitely. The controller samples RDY on the falling edge two cycles after its pulse, by which time RDY is already 0.
- ERR clears on acceptance of the next request.

Optional Feature:
- Macro: DMEM_TIMEOUT_EN.
- Defined:
  - Counter cleared on entry to ACCESS, incremented each ACCESS cycle.
  - Reaching TIMEOUT without MEM_ACK: drop strobes, go to RESP with ERR=1, RDATA unchanged.
  - A MEM_ACK in the same cycle the counter hits TIMEOUT counts as success.
- Undefined: no counter; ACCESS waits forever for MEM_ACK.

Decomposition:
- Shared package (core_pkg):
  - Load/store funct3 encodings (LB..LHU, SB..SW).
  - State encoding for IDLE/ACCESS/RESP.
  - Opcode constants shared with the controller.
- Sub-module lsu_align: purely combinational store lane steering/BE generation and load extract/extend; instantiated once, reusable by a future instruction-fetch path.

Test Plan:
- SW ADDR=0x100, WDATA=0xDEADBEEF, MEM_ACK 2 cycles after MEM_WE -> MEM_ADDR=0x100, BE=1111, MEM_WDATA=0xDEADBEEF, RDY low 4 cycles then high, ERR=0.
- LB ADDR=0x103, MEM_RDATA=0x80FF_0011 -> RDATA=0xFFFFFF80; LBU same -> 0x00000080; LH ADDR=0x102 -> 0xFFFF80FF.
- SH ADDR=0x101 -> no MEM_WE ever, ERR=1, RDY returns after 2 cycles; LW ADDR=0x102 likewise, RDATA unchanged.
- RREQ and CWE together, SB ADDR=0x2, WDATA=0xAB -> BE=0100, MEM_WDATA=0xABABABAB, ERR=1 at completion.
- RST_N low for 1 cycle during ACCESS -> MEM_RE drops asynchronously, RDY=1, next LW completes normally.
- With DMEM_TIMEOUT_EN, TIMEOUT=16, MEM_ACK never asserted -> strobe held exactly 16 cycles, ERR=1, RDY=1.

Source files
------------

// File: rtl/core_pkg.sv
// Shared core definitions: load/store funct3 encodings, LSU state encoding,
// major opcodes shared with the controller, and the request legality check.
package core_pkg;

  // load funct3
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  // store funct3
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // major opcodes decoded by the controller
  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCESS = 2'b01,
    ST_RESP   = 2'b10
  } lsu_state_t;

  // Legal funct3 for the direction, and natural alignment for the width.
  function automatic logic req_ok(input logic store, input logic [2:0] f3,
                                  input logic [1:0] lo);
    logic legal;
    logic aligned;
    if (store) legal = (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
    else       legal = (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
                       (f3 == F3_LBU) || (f3 == F3_LHU);
    case (f3[1:0])
      2'b01:   aligned = (lo[0] == 1'b0);
      2'b10:   aligned = (lo == 2'b00);
      default: aligned = 1'b1;
    endcase
    return legal && aligned;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane logic: store data replication and byte enables,
// load lane extraction with sign/zero extension. Kept standalone so a fetch
// path can reuse it.
module lsu_align
  import core_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [31:0] st_data,
  output logic [3:0]  st_be,
  output logic [31:0] ld_data
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // Store side: replicate the right-aligned datum on every lane, mask by BE.
  always_comb begin
    st_data = wdata;
    st_be   = 4'b1111;
    case (funct3[1:0])
      2'b00: begin
        st_data = {4{wdata[7:0]}};
        st_be   = 4'b0001 << addr_lo;
      end
      2'b01: begin
        st_data = {2{wdata[15:0]}};
        st_be   = 4'b0011 << addr_lo;
      end
      default: ;
    endcase
  end

  // Load side: pick the addressed lane, then extend per funct3.
  always_comb begin
    case (addr_lo)
      2'b00:   ld_byte = rdata[7:0];
      2'b01:   ld_byte = rdata[15:8];
      2'b10:   ld_byte = rdata[23:16];
      default: ld_byte = rdata[31:24];
    endcase
    ld_half = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    case (funct3)
      F3_LB:   ld_data = {{24{ld_byte[7]}}, ld_byte};
      F3_LH:   ld_data = {{16{ld_half[15]}}, ld_half};
      F3_LBU:  ld_data = {24'h0, ld_byte};
      F3_LHU:  ld_data = {16'h0, ld_half};
      default: ld_data = rdata;
    endcase
  end

endmodule

// File: rtl/data_mem_if.sv
// Load/store unit: one handshake transaction on the data-memory bus per
// controller request, with lane steering and load extension via lsu_align.
// Optional macro DMEM_TIMEOUT_EN aborts an access after TIMEOUT cycles
// without MEM_ACK.
module data_mem_if
  import core_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 16
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          RREQ,
  input  logic          CWE,
  input  logic [2:0]    FUNCT3,
  input  logic [AW-1:0] ADDR,
  input  logic [DW-1:0] WDATA,
  output logic          RDY,
  output logic [DW-1:0] RDATA,
  output logic          ERR,
  output logic [AW-1:0] MEM_ADDR,
  output logic [DW-1:0] MEM_WDATA,
  output logic [3:0]    MEM_BE,
  output logic          MEM_RE,
  output logic          MEM_WE,
  input  logic [DW-1:0] MEM_RDATA,
  input  logic          MEM_ACK
);

  lsu_state_t state, state_nxt;

  logic       accept;
  logic       ok;
  logic       tmo;
  logic [2:0] f3_q;
  logic [1:0] lo_q;
  logic       load_q;
  logic       both_q;
  logic [2:0] sel_f3;
  logic [1:0] sel_lo;
  logic [31:0] st_data, ld_data;
  logic [3:0]  st_be;

  assign accept = (state == ST_IDLE) && (RREQ || CWE);
  // a store wins when both pulses arrive together
  assign ok     = req_ok(CWE, FUNCT3, ADDR[1:0]);

  // Steering is only needed at acceptance (live inputs); extraction only
  // during ACCESS (latched request), so one aligner serves both.
  assign sel_f3 = (state == ST_IDLE) ? FUNCT3    : f3_q;
  assign sel_lo = (state == ST_IDLE) ? ADDR[1:0] : lo_q;

  lsu_align u_align (
    .funct3  (sel_f3),
    .addr_lo (sel_lo),
    .wdata   (WDATA),
    .rdata   (MEM_RDATA),
    .st_data (st_data),
    .st_be   (st_be),
    .ld_data (ld_data)
  );

`ifdef DMEM_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt;

  // Access-cycle counter, cleared on entry to ACCESS.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)                                   cnt <= '0;
    else if (accept)                              cnt <= '0;
    else if (state == ST_ACCESS && cnt != CW'(TIMEOUT)) cnt <= cnt + 1'b1;
  end

  // this edge closes the TIMEOUT-th access cycle
  assign tmo = (cnt == CW'(TIMEOUT - 1));
`else
  assign tmo = 1'b0;
`endif

  // State register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (accept) state_nxt = ok ? ST_ACCESS : ST_RESP;
      ST_ACCESS: if (MEM_ACK || tmo) state_nxt = ST_RESP;
      ST_RESP:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Request latch, bus drive, and result/status registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      RDY       <= 1'b1;
      ERR       <= 1'b0;
      RDATA     <= '0;
      MEM_ADDR  <= '0;
      MEM_WDATA <= '0;
      MEM_BE    <= '0;
      MEM_RE    <= 1'b0;
      MEM_WE    <= 1'b0;
      f3_q      <= '0;
      lo_q      <= '0;
      load_q    <= 1'b0;
      both_q    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (accept) begin
          RDY    <= 1'b0;
          f3_q   <= FUNCT3;
          lo_q   <= ADDR[1:0];
          load_q <= !CWE;
          both_q <= RREQ && CWE;
          // an illegal request reports its error on entering RESP
          ERR    <= !ok;
          if (ok) begin
            MEM_ADDR <= {ADDR[AW-1:2], 2'b00};
            MEM_RE   <= !CWE;
            MEM_WE   <= CWE;
            if (CWE) begin
              MEM_WDATA <= st_data;
              MEM_BE    <= st_be;
            end else begin
              MEM_BE    <= 4'b0000;
            end
          end
        end
        ST_ACCESS: begin
          if (MEM_ACK) begin
            MEM_RE <= 1'b0;
            MEM_WE <= 1'b0;
            ERR    <= both_q;
            if (load_q) RDATA <= ld_data;
          end else if (tmo) begin
            MEM_RE <= 1'b0;
            MEM_WE <= 1'b0;
            ERR    <= 1'b1;
          end
        end
        ST_RESP: RDY <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule
